// File: rtl/vanity_pkg.sv
// Shared constants and FSM state encoding for the vanity range loader.
package vanity_pkg;

    localparam int WORD_WIDTH        = 32;
    localparam int HASH_WIDTH        = 160;
    localparam int WORDS             = HASH_WIDTH / WORD_WIDTH;
    localparam int MATCH_COUNT_WIDTH = 32;

    typedef enum logic [2:0] {
        LOAD_MIN,
        LOAD_MAX,
        CHECK,
        ARMED,
        ERROR
    } state_t;

endpackage

// File: rtl/vanity_word_shifter.sv
// WORDS-deep shift-in register, most-significant word first; o_done flags the
// shift that completes a full value.
module vanity_word_shifter #(
    parameter int WORD_WIDTH = 32,
    parameter int WORDS      = 5
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        i_shift,
    input  logic [WORD_WIDTH-1:0]       i_word,
    output logic [WORDS*WORD_WIDTH-1:0] o_value,
    output logic                        o_done
);

    localparam int             IDX_W    = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

    logic [IDX_W-1:0]            r_index;
    logic [WORDS*WORD_WIDTH-1:0] r_value;
    logic [WORDS*WORD_WIDTH-1:0] w_next_value;

    generate
        if (WORDS > 1) begin : g_multi
            assign w_next_value = {r_value[WORDS*WORD_WIDTH-WORD_WIDTH-1:0], i_word};
        end else begin : g_single
            assign w_next_value = i_word;
        end
    endgenerate

    assign o_done  = i_shift && (r_index == LAST_IDX);
    assign o_value = r_value;

    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: the shadow value is reset too, so a reset mid-load leaves no
            // stale partial words behind; it is a handful of flops, not a RAM.
            r_index <= '0;
            r_value <= '0;
        end else if (i_shift) begin
            // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
            r_index <= o_done ? '0 : r_index + 1'b1;
            r_value <= w_next_value;
        end
    end

endmodule

// File: rtl/vanity_range_loader.sv
// Loads a min/max hash range from a word stream, validates it, commits it atomically
// and counts comparator matches. Define VANITY_RANGE_SWAP_EN to swap reversed ranges.
module vanity_range_loader #(
    parameter int WORD_WIDTH = vanity_pkg::WORD_WIDTH,
    parameter int HASH_WIDTH = vanity_pkg::HASH_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [WORD_WIDTH-1:0] rx_data,
    input  logic                  rx_valid,
    output logic                  tx_ready,
    output logic [HASH_WIDTH-1:0] tx_min,
    output logic [HASH_WIDTH-1:0] tx_max,
    output logic                  tx_enable,
    input  logic                  rx_match,
    output logic                  tx_error,
    output logic [31:0]           tx_match_count
);

    import vanity_pkg::*;

    localparam int NUM_WORDS = HASH_WIDTH / WORD_WIDTH;

    state_t r_state;
    state_t w_next_state;

    logic [HASH_WIDTH-1:0]        r_min;
    logic [HASH_WIDTH-1:0]        r_max;
    logic                         r_enable;
    logic                         r_error;
    logic [MATCH_COUNT_WIDTH-1:0] r_match_count;

    logic                  w_accept;
    logic                  w_shift_min;
    logic                  w_shift_max;
    logic                  w_min_done;
    logic                  w_max_done;
    logic                  w_commit;
    logic                  w_reject;
    logic [HASH_WIDTH-1:0] w_shadow_min;
    logic [HASH_WIDTH-1:0] w_shadow_max;
    logic [HASH_WIDTH-1:0] w_commit_min;
    logic [HASH_WIDTH-1:0] w_commit_max;

    assign tx_ready    = (r_state != CHECK);
    assign w_accept    = rx_valid && tx_ready;
    // A word arriving while armed or in error starts a fresh min load.
    assign w_shift_min = w_accept && (r_state inside {LOAD_MIN, ARMED, ERROR});
    assign w_shift_max = w_accept && (r_state == LOAD_MAX);

    vanity_word_shifter #(.WORD_WIDTH(WORD_WIDTH), .WORDS(NUM_WORDS)) u_min_shifter (
        .clk     (clk),
        .reset   (reset),
        .i_shift (w_shift_min),
        .i_word  (rx_data),
        .o_value (w_shadow_min),
        .o_done  (w_min_done)
    );

    vanity_word_shifter #(.WORD_WIDTH(WORD_WIDTH), .WORDS(NUM_WORDS)) u_max_shifter (
        .clk     (clk),
        .reset   (reset),
        .i_shift (w_shift_max),
        .i_word  (rx_data),
        .o_value (w_shadow_max),
        .o_done  (w_max_done)
    );

    always_comb begin
        // NOTE: every output of this block gets a default first so no latch is inferred.
        w_next_state = r_state;
        w_commit     = 1'b0;
        w_reject     = 1'b0;
        w_commit_min = w_shadow_min;
        w_commit_max = w_shadow_max;
        case (r_state)
            LOAD_MIN, ARMED, ERROR: begin
                if (w_shift_min) w_next_state = w_min_done ? LOAD_MAX : LOAD_MIN;
            end
            LOAD_MAX: begin
                if (w_max_done) w_next_state = CHECK;
            end
            CHECK: begin
                if (w_shadow_min <= w_shadow_max) begin
                    w_commit     = 1'b1;
                    w_next_state = ARMED;
                end else begin
`ifdef VANITY_RANGE_SWAP_EN
                    w_commit     = 1'b1;
                    w_commit_min = w_shadow_max;
                    w_commit_max = w_shadow_min;
                    w_next_state = ARMED;
`else
                    w_reject     = 1'b1;
                    w_next_state = ERROR;
`endif
                end
            end
            default: w_next_state = LOAD_MIN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= LOAD_MIN;
            r_min         <= '0;
            r_max         <= '0;
            r_enable      <= 1'b0;
            r_error       <= 1'b0;
            r_match_count <= '0;
        end else begin
            r_state  <= w_next_state;
            r_enable <= (w_next_state == ARMED);
            if (w_commit) begin
                r_min   <= w_commit_min;
                r_max   <= w_commit_max;
                r_error <= 1'b0;
            end else if (w_reject) begin
                r_error <= 1'b1;
            end
            // Commit clear wins over an in-flight match in the same cycle.
            if (w_commit) begin
                r_match_count <= '0;
            end else if (rx_match && (r_match_count != '1)) begin
                r_match_count <= r_match_count + 1'b1;
            end
        end
    end

    assign tx_min         = r_min;
    assign tx_max         = r_max;
    assign tx_enable      = r_enable;
    assign tx_error       = r_error;
    assign tx_match_count = r_match_count;

endmodule

// File: tb/tb_vanity_range_loader.sv
// Self-checking bench: word-list reference model compared every cycle, plus directed literals.
module tb_vanity_range_loader;

    import vanity_pkg::*;

    localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

    logic                  clk = 1'b0;
    logic                  reset;
    logic [WORD_WIDTH-1:0] rx_data;
    logic                  rx_valid;
    logic                  tx_ready;
    logic [HASH_WIDTH-1:0] tx_min;
    logic [HASH_WIDTH-1:0] tx_max;
    logic                  tx_enable;
    logic                  rx_match;
    logic                  tx_error;
    logic [31:0]           tx_match_count;

    int checks   = 0;
    int failures = 0;

    bit sat_load      = 1'b0;
    bit rand_match_en = 1'b0;

    vanity_range_loader dut (
        .clk            (clk),
        .reset          (reset),
        .rx_data        (rx_data),
        .rx_valid       (rx_valid),
        .tx_ready       (tx_ready),
        .tx_min         (tx_min),
        .tx_max         (tx_max),
        .tx_enable      (tx_enable),
        .rx_match       (rx_match),
        .tx_error       (tx_error),
        .tx_match_count (tx_match_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [HASH_WIDTH-1:0] act,
                         input logic [HASH_WIDTH-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: accepted words collected in a list, range built from it.
    logic [WORD_WIDTH-1:0] m_words[$];
    logic [HASH_WIDTH-1:0] m_min, m_max, m_lo, m_hi;
    logic [31:0]           m_count;
    bit                    m_enable, m_error, m_checking, m_commit;

    function automatic logic [HASH_WIDTH-1:0] words_to_hash(input int base);
        logic [HASH_WIDTH-1:0] v = '0;
        for (int i = 0; i < WORDS; i++) v = (v << WORD_WIDTH) | HASH_WIDTH'(m_words[base + i]);
        return v;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_words.delete();
            m_min = '0; m_max = '0; m_count = '0;
            m_enable = 0; m_error = 0; m_checking = 0;
        end else if (sat_load) begin
            m_count = 32'hFFFF_FFFE;
        end else begin
            m_commit = 0;
            if (m_checking) begin
                m_lo = words_to_hash(0);
                m_hi = words_to_hash(WORDS);
                m_words.delete();
                m_checking = 0;
                if (m_lo <= m_hi) begin
                    m_commit = 1; m_min = m_lo; m_max = m_hi;
                end else begin
`ifdef VANITY_RANGE_SWAP_EN
                    m_commit = 1; m_min = m_hi; m_max = m_lo;
`else
                    m_error = 1;
`endif
                end
                if (m_commit) begin
                    m_error = 0; m_enable = 1;
                end
            end else if (rx_valid) begin
                m_words.push_back(rx_data);
                m_enable = 0;
                if (m_words.size() == 2 * WORDS) m_checking = 1;
            end
            if (m_commit) m_count = '0;
            else if (rx_match && m_count != CNT_MAX) m_count = m_count + 1;
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            check("ready", tx_ready, !m_checking);
            check("enable", tx_enable, m_enable);
            check("error", tx_error, m_error);
            check("min", tx_min, m_min);
            check("max", tx_max, m_max);
            check("match_count", tx_match_count, m_count);
        end
    end

    task automatic drive_match();
        if (rand_match_en) rx_match = ($urandom_range(0, 3) == 0);
    endtask

    task automatic send_word(input logic [WORD_WIDTH-1:0] w, input int gap_pct);
        int n = 0;
        while ($urandom_range(0, 99) < gap_pct) begin
            rx_valid = 1'b0;
            rx_data  = $urandom;
            drive_match();
            @(negedge clk);
        end
        rx_valid = 1'b1;
        rx_data  = w;
        drive_match();
        while (!tx_ready && n < 8) begin
            @(negedge clk);
            n++;
        end
        if (n >= 8) begin
            checks++;
            failures++;
            $display("FAIL ready_timeout: tx_ready stayed 0 for %0d cycles, required 1", n);
        end
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic load_range(input logic [HASH_WIDTH-1:0] lo, input logic [HASH_WIDTH-1:0] hi,
                              input int gap_pct);
        for (int i = 0; i < WORDS; i++) send_word(lo[HASH_WIDTH-1-i*WORD_WIDTH -: WORD_WIDTH], gap_pct);
        for (int i = 0; i < WORDS; i++) send_word(hi[HASH_WIDTH-1-i*WORD_WIDTH -: WORD_WIDTH], gap_pct);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            rx_valid = 1'b0;
            drive_match();
            @(negedge clk);
        end
        if (rand_match_en) rx_match = 1'b0;
    endtask

    function automatic logic [HASH_WIDTH-1:0] rand_hash();
        logic [HASH_WIDTH-1:0] v = '0;
        for (int i = 0; i < WORDS; i++) v = (v << WORD_WIDTH) | HASH_WIDTH'($urandom);
        return v;
    endfunction

    logic [HASH_WIDTH-1:0] t_lo, t_hi, t_tmp;
    localparam logic [HASH_WIDTH-1:0] ONE  = 1;
    localparam logic [HASH_WIDTH-1:0] FF   = 'hFF;
    localparam logic [HASH_WIDTH-1:0] BEEF =
        160'hDEADBEEF_CAFEF00D_01234567_89ABCDEF_DEADBEEF;

    initial begin
        reset = 1'b1; rx_valid = 1'b0; rx_data = '0; rx_match = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("reset_ready", tx_ready, 1);
        check("reset_enable", tx_enable, 0);
        check("reset_count", tx_match_count, 0);

        // Back-to-back load, min = 1, max = 0xFF.
        load_range(ONE, FF, 0);
        check("t1_check_ready", tx_ready, 0);
        @(negedge clk);
        check("t1_enable", tx_enable, 1);
        check("t1_min", tx_min, ONE);
        check("t1_max", tx_max, FF);
        check("t1_error", tx_error, 0);

        // Reversed range.
        load_range(FF, ONE, 0);
        @(negedge clk);
`ifdef VANITY_RANGE_SWAP_EN
        check("t2_error", tx_error, 0);
        check("t2_enable", tx_enable, 1);
        check("t2_min", tx_min, ONE);
        check("t2_max", tx_max, FF);
`else
        check("t2_error", tx_error, 1);
        check("t2_enable", tx_enable, 0);
        check("t2_min_kept", tx_min, ONE);
        check("t2_max_kept", tx_max, FF);
`endif

        // Three matches while armed, then commit clear beats a same-cycle match.
        load_range(ONE, FF, 0);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            rx_match = 1'b1; @(negedge clk);
            rx_match = 1'b0; @(negedge clk);
        end
        check("t3_count3", tx_match_count, 3);
        rx_match = 1'b1;
        load_range(160'h2, 160'h1000, 0);
        @(negedge clk);
        check("t3_commit_clear", tx_match_count, 0);
        rx_match = 1'b0;

        // Abort while armed, then reset mid-load, then a fresh load.
        send_word(32'h1234_5678, 0);
        check("t4_abort_enable", tx_enable, 0);
        for (int i = 0; i < 6; i++) send_word($urandom, 0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("t4_reset_min", tx_min, 0);
        check("t4_reset_error", tx_error, 0);
        check("t4_reset_ready", tx_ready, 1);
        t_lo = rand_hash(); t_hi = rand_hash();
        if (t_lo > t_hi) begin t_tmp = t_lo; t_lo = t_hi; t_hi = t_tmp; end
        load_range(t_lo, t_hi, 0);
        @(negedge clk);
        check("t4_fresh_min", tx_min, t_lo);
        check("t4_fresh_max", tx_max, t_hi);

        // Single-value range with random gaps.
        load_range(BEEF, BEEF, 40);
        @(negedge clk);
        check("t5_min", tx_min, BEEF);
        check("t5_min_eq_max", tx_min, tx_max);
        check("t5_error", tx_error, 0);

        // Counter saturation.
        #1 force dut.r_match_count = 32'hFFFF_FFFE;
        sat_load = 1'b1;
        #1 release dut.r_match_count;
        @(negedge clk);
        sat_load = 1'b0;
        for (int i = 0; i < 3; i++) begin
            rx_match = 1'b1; @(negedge clk);
            rx_match = 1'b0; @(negedge clk);
        end
        check("t6_saturate", tx_match_count, CNT_MAX);

        // Randomized ranges, gaps and match pulses.
        rand_match_en = 1'b1;
        for (int r = 0; r < 12; r++) begin
            t_lo = rand_hash();
            case ($urandom_range(0, 3))
                0:       t_hi = t_lo;
                1:       t_hi = t_lo + HASH_WIDTH'($urandom_range(0, 3));
                default: t_hi = rand_hash();
            endcase
            load_range(t_lo, t_hi, 30);
            idle($urandom_range(1, 6));
        end
        rand_match_en = 1'b0;
        rx_match = 1'b0;
        idle(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/vanity_range_loader.md
Name: vanity_range_loader

Overview:
- Host-side loader that drives the range-compare stage's min/max/enable inputs.
- Assembles a 160-bit min and a 160-bit max from a 32-bit word stream (valid/ready), validates min <= max, then commits both atomically and arms the comparator.
- Counts match pulses returned by the comparator so the host can poll hit totals per loaded range.

Parameters:
- WORD_WIDTH, 32, host word width.
- HASH_WIDTH, 160, range/hash width; must be an integer multiple of WORD_WIDTH.
- Derived constant WORDS = HASH_WIDTH/WORD_WIDTH (5 at the defaults).

Ports:
- clk  in  1  single clock
- reset  in  1  synchronous, active-high reset
- rx_data  in  WORD_WIDTH  host word
- rx_valid  in  1  rx_data valid
- tx_ready  out  1  loader can accept a word this cycle
- tx_min  out  HASH_WIDTH  committed lower bound, to comparator min
- tx_max  out  HASH_WIDTH  committed upper bound, to comparator max
- tx_enable  out  1  comparator enable (drives its enable/rx_reset input)
- rx_match  in  1  registered match pulse from comparator
- tx_error  out  1  last loaded range rejected (min > max)
- tx_match_count  out  32  saturating matches since last commit

Behaviour:
- Reset values:
  - tx_min = 0, tx_max = 0.
  - tx_enable = 0, tx_error = 0, tx_match_count = 0.
  - tx_ready = 1.
  - State = LOAD_MIN, word index = 0.
- Handshake: a word is accepted in a cycle where rx_valid && tx_ready. tx_ready = 1 in every state except CHECK.
- Word order: most-significant word first. The first WORDS accepted words form min; the next WORDS form max.
- Words are shifted into shadow registers. tx_min and tx_max change only at commit, never mid-load.
- State LOAD_MIN:
  - Accept words into the shadow min, incrementing the word index.
  - On the WORDS-th word, go to LOAD_MAX and set index = 0.
- State LOAD_MAX:
  - Same as LOAD_MIN, filling the shadow max.
  - On the last word, go to CHECK.
- State CHECK (1 cycle, tx_ready = 0), compare the shadow registers (unsigned):
  - If shadow_min <= shadow_max: commit shadow values to tx_min/tx_max, clear tx_match_count, clear tx_error, go to ARMED.
  - Otherwise: set tx_error = 1, keep the previous tx_min/tx_max, go to ERROR.
- State ARMED:
  - tx_enable = 1.
  - An accepted word deasserts tx_enable on the next cycle and enters LOAD_MIN with that word as min word 0 (abort and reload).
- State ERROR:
  - tx_enable = 0; tx_error stays 1.
  - An accepted word enters LOAD_MIN as word 0. tx_error stays 1 until the next successful commit.
- tx_enable is registered:
  - It rises the cycle after the commit cycle, so the last max word accepted at cycle N gives CHECK at N+1 and tx_enable = 1 at N+2.
  - It falls the cycle after an abort word is accepted.
- Match counter:
  - Increments on rx_match = 1 in any state, so a pulse still in flight from the comparator's 1-cycle latency is counted.
  - Saturates at 0xFFFFFFFF.
  - The commit clear has priority over a same-cycle increment (result 0).
- reset mid-load discards all partial shadow data. There is no partial-word state carried across reset.
- The range is inclusive at both ends. min == max is legal (a single-value range).

Optional Feature:
- Macro VANITY_RANGE_SWAP_EN.
- When defined: in CHECK, if shadow_min > shadow_max, commit tx_min = shadow_max and tx_max = shadow_min, go to ARMED, and leave tx_error = 0. The ERROR state is unreachable and may be omitted.
- When undefined: reject, as described under Behaviour.

Decomposition:
- Shared package vanity_pkg holds:
  - HASH_WIDTH and WORD_WIDTH defaults.
  - The derived WORDS constant.
  - The state enum (LOAD_MIN, LOAD_MAX, CHECK, ARMED, ERROR).
  - MATCH_COUNT_WIDTH = 32.
- One natural sub-module: vanity_word_shifter, a WORDS-deep MSW-first shift-in register with a load-complete flag. It is instantiated twice (min, max).

Test Plan:
- Load min = 0x00000000_00000000_00000000_00000000_00000001, max = 0x00000000_...._000000FF with rx_valid held high → 10 words accepted on consecutive cycles, tx_ready low for 1 cycle, tx_enable = 1 two cycles after the last word, tx_min/tx_max match, tx_error = 0.
- Load min = 0x...FF, max = 0x...01 → tx_error = 1, tx_enable = 0, tx_min/tx_max retain the previous values. With VANITY_RANGE_SWAP_EN defined: committed as min = 0x...01, max = 0x...FF, tx_error = 0.
- While ARMED, pulse rx_match 3 times → tx_match_count = 3. Reload a range → count = 0 on the commit cycle even if rx_match = 1 that cycle.
- While ARMED, send one word → tx_enable drops on the next cycle. Assert reset after 7 words → state LOAD_MIN, all outputs at reset values. A fresh 10-word load then commits correctly.
- rx_valid toggling randomly (gaps) with min == max = 0xDEADBEEF_... → commit succeeds, tx_min == tx_max, tx_error = 0.
- Force tx_match_count to 0xFFFFFFFE, then 3 rx_match pulses → count holds at 0xFFFFFFFF.
